// File: rtl/gpu_kernel_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpu_kernel_loader                                                          |
// | Streams a kernel into inst_mem, launches gpu_core, drains, reports cycles. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gpu_kernel_loader #(
    parameter int IMEM_DEPTH   = 128,
    parameter int IMEM_AW      = 7,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_CYCLES   = 1048576
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [31:0]        load_data,
    input  logic               load_last,
    input  logic               launch,
    input  logic               clear,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               core_rst_n,
    input  logic               core_halted,
    output logic               busy,
    output logic               done,
    output logic [IMEM_AW:0]   prog_len,
    output logic [31:0]        cycle_count,
    output logic               err_overflow,
    output logic               err_timeout
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_READY = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int                   c_drain_w    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_drain_w-1:0] c_drain_init = c_drain_w'(DRAIN_CYCLES - 1);
    localparam logic [31:0]          c_max_last   = 32'(MAX_CYCLES - 1);
    localparam logic [IMEM_AW:0]     c_depth      = (IMEM_AW + 1)'(IMEM_DEPTH);

    state_t                 state_q, state_d;
    logic [IMEM_AW:0]       wr_ptr_q, wr_ptr_d;
    logic [31:0]            cycle_count_q, cycle_count_d;
    logic [c_drain_w-1:0]   drain_q, drain_d;
    logic                   ovf_q, ovf_d;
    logic                   tmo_q, tmo_d;
    logic                   core_rst_n_q, core_rst_n_d;

    logic                   w_accept;
    logic                   w_room;

    assign w_accept = (state_q == S_LOAD) && load_valid;
    assign w_room   = (wr_ptr_q < c_depth);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_LOAD;
            wr_ptr_q      <= '0;
            cycle_count_q <= '0;
            drain_q       <= '0;
            ovf_q         <= 1'b0;
            tmo_q         <= 1'b0;
            core_rst_n_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            cycle_count_q <= cycle_count_d;
            drain_q       <= drain_d;
            ovf_q         <= ovf_d;
            tmo_q         <= tmo_d;
            core_rst_n_q  <= core_rst_n_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        cycle_count_d = cycle_count_q;
        drain_d       = drain_q;
        ovf_d         = ovf_q;
        tmo_d         = tmo_q;

        case (state_q)
            S_LOAD: begin
                if (w_accept) begin
                    if (w_room) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY, S_DONE: begin
                // launch outranks clear when both pulse together
                if (launch) begin
                    state_d       = S_RUN;
                    cycle_count_d = '0;
                    tmo_d         = 1'b0;
                end else if (clear) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                    ovf_d    = 1'b0;
                    tmo_d    = 1'b0;
                end
            end
            S_RUN: begin
                // the halt edge is itself a counted RUN cycle; the timeout edge is not
                if (core_halted) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                    drain_d       = c_drain_init;
                    state_d       = S_DRAIN;
                end else if (cycle_count_q == c_max_last) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        core_rst_n_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    assign load_ready   = (state_q == S_LOAD);
    assign imem_we      = w_accept && w_room;
    assign imem_waddr   = wr_ptr_q[IMEM_AW-1:0];
    assign imem_wdata   = load_data;
    assign core_rst_n   = core_rst_n_q;
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign prog_len     = wr_ptr_q;
    assign cycle_count  = cycle_count_q;
    assign err_overflow = ovf_q;
    assign err_timeout  = tmo_q;

endmodule
`default_nettype wire

// File: doc/gpu_kernel_loader.md
# gpu_kernel_loader

Host-facing launch controller that sits directly upstream of `gpu_core`. It streams a kernel program into the instruction-memory write port, holds the core in reset while loading, releases it on `launch`, and watches the core's `halted` flag. After a fixed pipeline drain it reports completion with a cycle count. Overflow and timeout errors are flagged without wedging the controller.

## Interface
- `IMEM_DEPTH`, default 128: number of instruction words in inst_mem.
- `IMEM_AW`, default 7: inst_mem address width; `2**IMEM_AW == IMEM_DEPTH`.
- `DRAIN_CYCLES`, default 4: cycles held in DRAIN after halt is seen, so the last load or tensor writeback retires.
- `MAX_CYCLES`, default 1048576: RUN-cycle limit before timeout.
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `load_valid` in 1: host program word valid.
- `load_ready` out 1: loader accepts a word this cycle.
- `load_data` in 32: instruction word.
- `load_last` in 1: marks the final word of the program.
- `launch` in 1: single-cycle pulse that starts execution.
- `clear` in 1: single-cycle pulse that discards the program and returns to LOAD.
- `imem_we` out 1: inst_mem write enable.
- `imem_waddr` out IMEM_AW: inst_mem write address.
- `imem_wdata` out 32: inst_mem write data.
- `core_rst_n` out 1: registered active-low reset to `gpu_core`.
- `core_halted` in 1: the core's registered `halted` flag.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE.
- `prog_len` out IMEM_AW+1: count of words stored, saturating at IMEM_DEPTH.
- `cycle_count` out 32: number of RUN cycles in the last or current run.
- `err_overflow` out 1: a word arrived after inst_mem was full.
- `err_timeout` out 1: the run hit MAX_CYCLES without a halt.

## Operation
- States and transitions:
  - LOAD: on accepted `load_last`, go to READY.
  - READY: on `launch`, go to RUN.
  - RUN: on `core_halted`, go to DRAIN; on timeout, go to DONE.
  - DRAIN: when the drain counter reaches 0, go to DONE.
  - DONE: on `launch`, go to RUN; on `clear`, go to LOAD.
  - `clear` in READY or DONE also goes to LOAD.
  - `clear` is ignored in RUN and DRAIN.
  - `launch` is ignored outside READY and DONE.
- LOAD:
  - `load_ready` = 1.
  - On `load_valid & load_ready`, if `wr_ptr < IMEM_DEPTH`: drive `imem_we` = 1, `imem_waddr` = `wr_ptr`, `imem_wdata` = `load_data`; then increment `wr_ptr` and `prog_len`.
  - If `wr_ptr == IMEM_DEPTH`: the word is accepted and dropped, `imem_we` = 0, `err_overflow` is set and stays set until the next `clear`.
  - `imem_*` are combinational from the handshake, so writes happen in the accept cycle.
- READY: `load_ready` = 0. Program contents are preserved.
- RUN:
  - `core_rst_n` = 1 and `cycle_count` increments every cycle.
  - Halt has priority over timeout in the same cycle.
  - Timeout fires when `cycle_count == MAX_CYCLES-1` with no halt. It sets `err_timeout` and goes straight to DONE, skipping DRAIN.
- DRAIN: `core_rst_n` stays 1 and the drain counter counts down from DRAIN_CYCLES-1. `cycle_count` is frozen.
- DONE:
  - `core_rst_n` = 0, which clears the core's `halted`.
  - On re-`launch`: `cycle_count` is cleared to 0 and `err_timeout` is cleared. The program is reused.
- `clear` zeroes `wr_ptr`, `prog_len`, `err_overflow` and `err_timeout`. inst_mem contents are not erased.
- `core_rst_n` is low in LOAD, READY and DONE, so the core never fetches a partially written program.

## Timing
- Reset values: state = LOAD; `load_ready` = 1; `core_rst_n` = 0; `busy` = 0; `done` = 0; `prog_len` = 0; `cycle_count` = 0; both error flags = 0; `imem_we` = 0.
- `launch` sampled at edge t:
  - State = RUN, `core_rst_n` = 1 and `cycle_count` = 0 after edge t.
  - Count is 1 after edge t+1.
- `core_halted` sampled high at edge h: DRAIN follows h, and DONE is reached DRAIN_CYCLES edges later with `done` = 1.
- `rst` asserted mid-run: `core_rst_n` drops asynchronously in the same instant and all state returns to the reset values.
- `clear` and `load_valid` in the same cycle in DONE: `clear` wins and the word is not accepted.
- `launch` and `clear` in the same cycle: `launch` wins.

## Test plan
- Load a program of 3 words [0x0011_0000, 0x1022_1000, 0xF000_0000] with `last` on word 3:
  - Required: writes to addresses 0, 1, 2 with matching data, `prog_len` = 3, state = READY, `load_ready` = 0, `core_rst_n` = 0.
- Launch, then drive `core_halted` high 10 cycles after launch:
  - Required: `busy` = 1 for 10 + DRAIN_CYCLES cycles, then `done` = 1, `cycle_count` = 10, `core_rst_n` = 0 in DONE.
- Stream 130 words with `last` on word 130:
  - Required: exactly 128 `imem_we` pulses (addresses 0..127), `err_overflow` = 1, `prog_len` = 128, state READY.
- Run with MAX_CYCLES = 16 and `core_halted` held low:
  - Required: DONE after 16 RUN cycles, `err_timeout` = 1, `cycle_count` = 15, no DRAIN.
- After DONE, `launch` again:
  - Required: `cycle_count` restarts at 0, `err_timeout` clears, no `imem_we` activity.
  - Then `clear`: required `prog_len` = 0 and `load_ready` = 1.
- Assert `rst` 5 cycles into RUN:
  - Required: `core_rst_n` goes low immediately, all outputs take their reset values, and a fresh load works.
